// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
// The FSM state enum, error codes and the default frame marker live here.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StLen0,
    StLen1,
    StData,
    StCsum,
    StDone,
    StError
  } loader_state_e;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_SYNC = 2'd1;
  localparam logic [1:0] ERR_LEN  = 2'd2;
  localparam logic [1:0] ERR_CSUM = 2'd3;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // States in which the loader consumes stream bytes.
  function automatic logic accepts_bytes(loader_state_e s);
    return (s == StSync) || (s == StLen0) || (s == StLen1) || (s == StData) || (s == StCsum);
  endfunction

  // States from which a start pulse re-arms the loader.
  function automatic logic is_armable(loader_state_e s);
    return (s == StIdle) || (s == StDone) || (s == StError);
  endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Collects little-endian stream bytes into 32-bit words; word_complete flags the
// cycle in which the 4th byte is accepted, with packed_word already assembled.
module imem_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] packed_word,
  output logic        word_complete
);

  logic [1:0]  idx_q;
  logic [23:0] low_q;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      idx_q <= 2'd0;
      low_q <= 24'd0;
    end else if (byte_valid) begin
      idx_q <= idx_q + 2'd1;
      case (idx_q)
        2'd0:    low_q[7:0]   <= byte_in;
        2'd1:    low_q[15:8]  <= byte_in;
        2'd2:    low_q[23:16] <= byte_in;
        default: ;
      endcase
    end
  end

  // The top byte is taken straight from the input so the word is ready a cycle earlier.
  assign packed_word   = {byte_in, low_q};
  assign word_complete = byte_valid && (idx_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a framed byte stream, writes instruction words into imem
// and releases cpu_hold only once the whole image has passed its XOR checksum.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned ADDR_W    = 10,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   words_loaded
);

  loader_state_e state_q, state_d;

  logic [15:0] len_q;
  logic [7:0]  csum_q;
  logic        accept;
  logic        arm;
  logic [15:0] len_full;
  logic        len_bad;
  logic        last_word;
  logic [31:0] packed_word;
  logic        word_complete;

  assign accept    = rx_valid && rx_ready;
  assign arm       = start && is_armable(state_q);
  assign len_full  = {rx_data, len_q[7:0]};
  assign len_bad   = (len_full == 16'd0) || (len_full > 16'(DEPTH));
  assign last_word = (16'(words_loaded) + 16'd1) == len_q;

  imem_word_packer u_packer (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear         (arm),
    .byte_valid    (accept && (state_q == StData)),
    .byte_in       (rx_data),
    .packed_word   (packed_word),
    .word_complete (word_complete)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone, StError: if (start) state_d = StSync;
      StSync: if (accept) state_d = (rx_data == SYNC_BYTE) ? StLen0 : StError;
      StLen0: if (accept) state_d = StLen1;
      StLen1: if (accept) state_d = len_bad ? StError : StData;
      StData: if (word_complete && last_word) state_d = StCsum;
      StCsum: if (accept) state_d = (rx_data == csum_q) ? StDone : StError;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      rx_ready     <= 1'b0;
      imem_we      <= 1'b0;
      imem_waddr   <= '0;
      imem_wdata   <= 32'd0;
      cpu_hold     <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      err_code     <= ERR_NONE;
      words_loaded <= '0;
      len_q        <= 16'd0;
      csum_q       <= 8'd0;
    end else begin
      state_q  <= state_d;
      // Status flags follow the next state so every output is a plain register.
      rx_ready <= accepts_bytes(state_d);
      busy     <= accepts_bytes(state_d);
      cpu_hold <= (state_d != StDone);
      done     <= (state_d == StDone);
      error    <= (state_d == StError);
      imem_we  <= 1'b0;

      unique case (state_q)
        StIdle, StDone, StError: begin
          if (start) begin
            err_code     <= ERR_NONE;
            words_loaded <= '0;
            csum_q       <= 8'd0;
            len_q        <= 16'd0;
          end
        end
        StSync: if (accept && rx_data != SYNC_BYTE) err_code <= ERR_SYNC;
        StLen0: if (accept) len_q[7:0] <= rx_data;
        StLen1: begin
          if (accept) begin
            len_q[15:8] <= rx_data;
            if (len_bad) err_code <= ERR_LEN;
          end
        end
        StData: begin
          if (accept) csum_q <= csum_q ^ rx_data;
          if (word_complete) begin
            imem_we      <= 1'b1;
            imem_waddr   <= words_loaded[ADDR_W-1:0];
            imem_wdata   <= packed_word;
            words_loaded <= words_loaded + 1'b1;
          end
        end
        StCsum: if (accept && rx_data != csum_q) err_code <= ERR_CSUM;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frame driver with a write scoreboard
// that also checks each write lands exactly one cycle after its 4th byte.
module tb_imem_loader;

  localparam int unsigned ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        rx_data = 8'd0;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              error;
  logic [1:0]        err_code;
  logic [ADDR_W:0]   words_loaded;

  imem_loader #(
    .DEPTH     (1024),
    .ADDR_W    (ADDR_W),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .imem_we      (imem_we),
    .imem_waddr   (imem_waddr),
    .imem_wdata   (imem_wdata),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .err_code     (err_code),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [41:0] exp_wr_q[$];
  int          exp_cyc_q[$];
  logic [7:0]  frame[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Write monitor: every imem_we must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && imem_we === 1'b1) begin
      if (exp_wr_q.size() == 0) begin
        check_eq("unexpected_write", {22'd0, imem_waddr}, 32'hFFFF_FFFF);
      end else begin
        check_eq("waddr", {22'd0, imem_waddr}, {22'd0, exp_wr_q[0][41:32]});
        check_eq("wdata", imem_wdata, exp_wr_q[0][31:0]);
        void'(exp_wr_q.pop_front());
      end
      if (exp_cyc_q.size() == 0) begin
        check_eq("we_timing_missing", 32'd1, 32'd0);
      end else begin
        check_eq("we_cycle", cyc, exp_cyc_q[0]);
        void'(exp_cyc_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit fourth, input int gap);
    int waited;
    waited = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    while (rx_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (rx_ready !== 1'b1) begin
      check_eq("rx_ready_timeout", 32'd0, 32'd1);
      rx_valid = 1'b0;
      tick(1);
      return;
    end
    if (fourth) exp_cyc_q.push_back(cyc + 1);
    tick(1);
    rx_valid = 1'b0;
    if (gap > 0) tick(gap);
  endtask

  // Pushes the writes implied by the frame bytes, then drives them.
  task automatic send_frame(input int gap);
    int n;
    int sz;
    sz = frame.size();
    n  = (sz >= 3) ? {frame[2], frame[1]} : 0;
    for (int w = 0; w < n; w++) begin
      if (3 + 4 * w + 3 < sz)
        exp_wr_q.push_back({w[ADDR_W-1:0], frame[3+4*w+3], frame[3+4*w+2],
                            frame[3+4*w+1], frame[3+4*w]});
    end
    for (int i = 0; i < sz; i++) begin
      send_byte(frame[i], (i >= 3) && (i < 3 + 4 * n) && (((i - 3) % 4) == 3), gap);
    end
  endtask

  task automatic check_status(input string tag, input logic exp_done, input logic exp_err,
                              input logic [1:0] exp_code, input logic exp_hold,
                              input int exp_words);
    check_eq({tag, "_done"}, {31'd0, done}, {31'd0, exp_done});
    check_eq({tag, "_error"}, {31'd0, error}, {31'd0, exp_err});
    check_eq({tag, "_err_code"}, {30'd0, err_code}, {30'd0, exp_code});
    check_eq({tag, "_cpu_hold"}, {31'd0, cpu_hold}, {31'd0, exp_hold});
    check_eq({tag, "_words"}, {21'd0, words_loaded}, exp_words);
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
    check_eq({tag, "_imem_we"}, {31'd0, imem_we}, 32'd0);
    check_eq({tag, "_waddr"}, {22'd0, imem_waddr}, 32'd0);
    check_eq({tag, "_wdata"}, imem_wdata, 32'd0);
    check_eq({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd1);
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_done"}, {31'd0, done}, 32'd0);
    check_eq({tag, "_error"}, {31'd0, error}, 32'd0);
    check_eq({tag, "_err_code"}, {30'd0, err_code}, 32'd0);
    check_eq({tag, "_words"}, {21'd0, words_loaded}, 32'd0);
  endtask

  task automatic load_nominal(input logic [7:0] csum);
    frame = '{8'hA5, 8'h02, 8'h00, 8'h05, 8'h00, 8'h40, 8'h14,
              8'h0A, 8'h00, 8'h80, 8'h14, 8'hCF};
    frame[11] = csum;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tick(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick(2);

    // Nominal two-word image.
    pulse_start();
    check_eq("armed_busy", {31'd0, busy}, 32'd1);
    check_eq("armed_rx_ready", {31'd0, rx_ready}, 32'd1);
    load_nominal(8'hCF);
    send_frame(0);
    tick(2);
    check_status("nominal", 1'b1, 1'b0, 2'd0, 1'b0, 2);

    // Restart from DONE re-holds the CPU, then a bad sync byte.
    pulse_start();
    check_eq("restart_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    check_eq("restart_done", {31'd0, done}, 32'd0);
    check_eq("restart_busy", {31'd0, busy}, 32'd1);
    frame = '{8'h5A};
    send_frame(0);
    tick(2);
    check_status("bad_sync", 1'b0, 1'b1, 2'd1, 1'b1, 0);

    // Bytes offered in ERROR must not be consumed.
    rx_data  = 8'hA5;
    rx_valid = 1'b1;
    tick(3);
    check_eq("error_no_accept", {31'd0, rx_ready}, 32'd0);
    check_eq("error_sticky", {30'd0, err_code}, 32'd1);
    rx_valid = 1'b0;

    pulse_start();
    frame = '{8'hA5, 8'h00, 8'h00};
    send_frame(0);
    tick(2);
    check_status("len_zero", 1'b0, 1'b1, 2'd2, 1'b1, 0);

    pulse_start();
    frame = '{8'hA5, 8'h01, 8'h04};
    send_frame(0);
    tick(2);
    check_status("len_1025", 1'b0, 1'b1, 2'd2, 1'b1, 0);

    pulse_start();
    load_nominal(8'hCE);
    send_frame(0);
    tick(2);
    check_status("bad_csum", 1'b0, 1'b1, 2'd3, 1'b1, 2);

    pulse_start();
    load_nominal(8'hCF);
    send_frame(3);
    tick(2);
    check_status("backpressure", 1'b1, 1'b0, 2'd0, 1'b0, 2);

    // Reset after 6 data bytes: word 0 written, nothing afterwards.
    pulse_start();
    load_nominal(8'hCF);
    frame = frame[0:8];
    send_frame(0);
    rst_n = 1'b0;
    tick(1);
    check_reset_outputs("mid_reset");
    rst_n = 1'b1;
    tick(4);
    check_eq("mid_reset_pending", exp_wr_q.size(), 32'd0);

    pulse_start();
    load_nominal(8'hCF);
    send_frame(0);
    tick(2);
    check_status("after_reset", 1'b1, 1'b0, 2'd0, 1'b0, 2);

    tick(3);
    check_eq("pending_writes", exp_wr_q.size(), 32'd0);
    check_eq("pending_timing", exp_cyc_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
